psg_bus_master: RTL

//  Bus initiator for a YM2149/AY-3-8910-style PSG. It accepts register write/read

---
 rtl/psg_bus_master_if.sv | 21 ++
 rtl/psg_bus_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/psg_bus_master_if.sv
// Request/response channel between a sound sequencer and the PSG bus master.
// The sequencer drives requests through master; the bus master answers through slave.
interface psg_bus_master_if;
   logic       REQ_VALID;
   logic       REQ_READY;
   logic       REQ_WR;
   logic [3:0] REQ_ADDR;
   logic [7:0] REQ_DATA;
   logic       RSP_VALID;
   logic [7:0] RSP_DATA;

   modport master (
      output REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA,
      input  REQ_READY, RSP_VALID, RSP_DATA
   );

   modport slave (
      input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA,
      output REQ_READY, RSP_VALID, RSP_DATA
   );
endinterface

// File: rtl/psg_bus_master.sv
// Buffers PSG register requests in a small FIFO and replays them as BDIR/BC bus cycles,
// skipping the address phase when the PSG already has the requested register latched.
module psg_bus_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int PHASE_CYC  = 2
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             CE,
   psg_bus_master_if.slave  req_if,
   output logic             BUSY,
   output logic             BDIR,
   output logic             BC,
   output logic [7:0]       DO,
   input  logic [7:0]       DI
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
   localparam logic [PW-1:0] PHASE_LOAD = PW'(PHASE_CYC - 1);
   localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_GAP,
      S_DATA,
      S_END
   } state_t;

   logic [12:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;

   state_t        state_reg;
   logic [PW-1:0] phase_reg;
   logic          cmd_wr_reg;
   logic [3:0]    cmd_addr_reg;
   logic [7:0]    cmd_data_reg;
   logic          cache_valid_reg;
   logic [3:0]    cache_addr_reg;
   logic          rsp_valid_reg;
   logic [7:0]    rsp_data_reg;

   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic [12:0] head;
   logic        head_wr;
   logic [3:0]  head_addr;
   logic [7:0]  head_data;
   logic        head_hit;

   assign fifo_full  = (count_reg == FIFO_FULL);
   assign fifo_empty = (count_reg == '0);
   assign push       = req_if.REQ_VALID & ~fifo_full;
   assign pop        = CE & (state_reg == S_IDLE) & ~fifo_empty;

   assign head      = fifo_mem[rd_ptr_reg];
   assign head_wr   = head[12];
   assign head_addr = head[11:8];
   assign head_data = head[7:0];
   assign head_hit  = cache_valid_reg && (cache_addr_reg == head_addr);

   assign req_if.REQ_READY = ~fifo_full;
   assign req_if.RSP_VALID = rsp_valid_reg;
   assign req_if.RSP_DATA  = rsp_data_reg;
   assign BUSY             = (state_reg != S_IDLE) || ~fifo_empty;

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {req_if.REQ_WR, req_if.REQ_ADDR, req_if.REQ_DATA};
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Bus outputs are loaded together with the state they belong to, so they stay registered.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg       <= S_IDLE;
         phase_reg       <= '0;
         cmd_wr_reg      <= 1'b0;
         cmd_addr_reg    <= '0;
         cmd_data_reg    <= '0;
         cache_valid_reg <= 1'b0;
         cache_addr_reg  <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_data_reg    <= '0;
         BDIR            <= 1'b0;
         BC              <= 1'b0;
         DO              <= '0;
      end else begin
         rsp_valid_reg <= 1'b0;
         if (CE) begin
            case (state_reg)
               S_IDLE: begin
                  if (!fifo_empty) begin
                     cmd_wr_reg   <= head_wr;
                     cmd_addr_reg <= head_addr;
                     cmd_data_reg <= head_data;
                     phase_reg    <= PHASE_LOAD;
                     if (head_hit) begin
                        state_reg <= S_DATA;
                        BDIR      <= head_wr;
                        BC        <= ~head_wr;
                        DO        <= head_wr ? head_data : 8'h00;
                     end else begin
                        state_reg <= S_ADDR;
                        BDIR      <= 1'b1;
                        BC        <= 1'b1;
                        DO        <= {4'h0, head_addr};
                     end
                  end
               end
               S_ADDR: begin
                  if (phase_reg == '0) begin
                     state_reg       <= S_GAP;
                     cache_addr_reg  <= cmd_addr_reg;
                     cache_valid_reg <= 1'b1;
                     BDIR            <= 1'b0;
                     BC              <= 1'b0;
                     DO              <= 8'h00;
                  end else begin
                     phase_reg <= phase_reg - 1'b1;
                  end
               end
               S_GAP: begin
                  state_reg <= S_DATA;
                  phase_reg <= PHASE_LOAD;
                  BDIR      <= cmd_wr_reg;
                  BC        <= ~cmd_wr_reg;
                  DO        <= cmd_wr_reg ? cmd_data_reg : 8'h00;
               end
               S_DATA: begin
                  if (phase_reg == '0) begin
                     state_reg <= S_END;
                     BDIR      <= 1'b0;
                     BC        <= 1'b0;
                     DO        <= 8'h00;
                     if (!cmd_wr_reg) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= DI;
                     end
                  end else begin
                     phase_reg <= phase_reg - 1'b1;
                  end
               end
               S_END: begin
                  state_reg <= S_IDLE;
               end
               default: begin
                  state_reg <= S_IDLE;
                  BDIR      <= 1'b0;
                  BC        <= 1'b0;
                  DO        <= 8'h00;
               end
            endcase
         end
      end
   end

endmodule
